// File: rtl/myo_spi_slave_if.sv
// myo_spi_slave_if: SPI pin bundle between the forearm master and the muscle-unit slave
interface myo_spi_slave_if;
  logic sck;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;
  modport master (output sck, ss_n, mosi, input miso, miso_oe);
  modport slave (input sck, ss_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/myo_spi_slave.sv
// myo_spi_slave: oversampled SPI mode-0 responder for myocontrol frames; define MYO_SPI_SLAVE_CHECKSUM_EN for XOR-checked last word
module myo_spi_slave #(
  parameter int FRAME_WORDS = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  myo_spi_slave_if.slave        spi,
  input  logic [31:0]           position,
  input  logic [31:0]           velocity,
  input  logic [15:0]           displacement,
  input  logic [15:0]           current,
  input  logic [7:0]            status,
  output logic [7:0]            control_mode,
  output logic [15:0]           pwm_ref,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic [15:0]           frame_count
);
  localparam int NB = FRAME_WORDS * 16;
  localparam int CW = $clog2(NB + 2);
  localparam logic [CW-1:0] NB_C = CW'(NB);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CHECK} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
  logic                   sck_d, ss_d;
  logic                   sck_s, ss_s, mosi_s;
  logic                   ss_edge, ss_rise, ss_fall, sck_rise, sck_fall;
  logic [NB-1:0]          tx_sr, rx_sr, tx_frame;
  logic [CW-1:0]          cnt;
  logic [15:0]            tx_last;
  logic                   miso_r, ok;

  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign ss_s     = ss_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign ss_edge  = ss_s ^ ss_d;
  assign ss_rise  = ss_s & ~ss_d;
  assign ss_fall  = ~ss_s & ss_d;
  assign sck_rise = sck_s & ~sck_d & ~ss_edge;
  assign sck_fall = ~sck_s & sck_d & ~ss_edge;
  assign spi.miso    = miso_r;
  assign spi.miso_oe = ~ss_s;

`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
  logic [15:0] rx_xor;
  assign tx_last = {8'h80, status} ^ position[31:16] ^ position[15:0] ^
                   velocity[31:16] ^ velocity[15:0] ^ displacement ^ current;
  // XOR of every received word except the last; rx word 0 sits at the top of rx_sr
  always_comb begin
    rx_xor = '0;
    for (int k = 1; k < FRAME_WORDS; k++) rx_xor = rx_xor ^ rx_sr[k*16 +: 16];
  end
  assign ok = (cnt == NB_C) && (rx_xor == rx_sr[15:0]);
`else
  assign tx_last = '0;
  assign ok      = cnt == NB_C;
`endif

  // status frame image, word 0 in the top 16 bits so it shifts out first
  always_comb begin
    tx_frame = '0;
    tx_frame[NB-1 -: 112] = {8'h80, status, position, velocity, displacement, current};
    tx_frame[15:0] = tx_last;
  end

  // bring the SPI pins into clk_clk; the extra _d stage feeds edge detection
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sck_q  <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], spi.sck};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], spi.ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi.mosi};
      sck_d  <= sck_s;
      ss_d   <= ss_s;
    end
  end

  // frame FSM: snapshot, shift both directions, then accept or reject; cnt parks at NB+1 on overlong frames
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      tx_sr        <= '0;
      rx_sr        <= '0;
      cnt          <= '0;
      miso_r       <= 1'b0;
      control_mode <= '0;
      pwm_ref      <= '0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      frame_count  <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= frame_count + {15'd0, state == CHECK && ok};
      case (state)
        IDLE: if (ss_fall) state <= LOAD;
        LOAD: begin
          tx_sr  <= tx_frame;
          miso_r <= tx_frame[NB-1];
          cnt    <= '0;
          state  <= ss_rise ? CHECK : SHIFT;
        end
        SHIFT: begin
          if (ss_rise) state <= CHECK;
          else if (sck_rise && cnt <= NB_C) begin
            cnt <= cnt + 1'b1;
            if (cnt < NB_C) rx_sr <= {rx_sr[NB-2:0], mosi_s};
          end else if (sck_fall) begin
            tx_sr  <= tx_sr << 1;
            miso_r <= (cnt < NB_C) & tx_sr[NB-2];
          end
        end
        CHECK: begin
          frame_valid <= ok;
          frame_error <= !ok;
          miso_r      <= 1'b0;
          if (ok) begin
            control_mode <= rx_sr[NB-9 -: 8];
            pwm_ref      <= rx_sr[NB-17 -: 16];
          end
          state <= ss_fall ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_myo_spi_slave.sv
// tb_myo_spi_slave: randomized frame-level bench against a word-level model of myo_spi_slave
module tb_myo_spi_slave;
  localparam int SYNC = 2;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [31:0] position = '0, velocity = '0;
  logic [15:0] displacement = '0, current = '0;
  logic [7:0]  status = '0;
  logic [7:0]  control_mode;
  logic [15:0] pwm_ref, frame_count;
  logic        frame_valid, frame_error;

  myo_spi_slave_if spi();

  myo_spi_slave #(.FRAME_WORDS(8), .SYNC_STAGES(SYNC)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .spi(spi),
    .position(position), .velocity(velocity), .displacement(displacement),
    .current(current), .status(status), .control_mode(control_mode),
    .pwm_ref(pwm_ref), .frame_valid(frame_valid), .frame_error(frame_error),
    .frame_count(frame_count)
  );

  always #5 clk_clk = ~clk_clk;

  int          checks = 0, errors = 0;
  logic [15:0] mw[8];
  logic [15:0] sw[8];
  logic [15:0] ew[8];
  int          n_valid, n_error, lat, mid_bit = -1;
  logic [15:0] fc_at_pulse;
  logic        oe_ok;
  logic [31:0] pos_mid;
  logic [7:0]  m_mode = '0;
  logic [15:0] m_pwm = '0, m_count = '0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_clk); #1; end
  endtask

  task automatic expect_words();
    ew[0] = {8'h80, status};
    ew[1] = position[31:16];
    ew[2] = position[15:0];
    ew[3] = velocity[31:16];
    ew[4] = velocity[15:0];
    ew[5] = displacement;
    ew[6] = current;
    ew[7] = '0;
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
    for (int i = 0; i < 7; i++) ew[7] ^= ew[i];
`endif
  endtask

  task automatic seal_checksum();
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
    mw[7] = '0;
    for (int i = 0; i < 7; i++) mw[7] ^= mw[i];
`endif
  endtask

  task automatic randomize_inputs();
    position     = $urandom;
    velocity     = $urandom;
    displacement = 16'($urandom);
    current      = 16'($urandom);
    status       = 8'($urandom);
    for (int i = 0; i < 8; i++) mw[i] = 16'($urandom);
    seal_checksum();
  endtask

  task automatic xfer(input int nbits, input int gap);
    logic [15:0] w;
    n_valid = 0;
    n_error = 0;
    lat = -1;
    oe_ok = 1'b1;
    spi.ss_n = 1'b0;
    tick(8);
    for (int b = 0; b < nbits; b++) begin
      if (b == mid_bit) position = pos_mid;
      w = (b < 128) ? mw[b/16] : 16'($urandom);
      spi.mosi = w[15 - b%16];
      tick(8);
      if (b < 128) sw[b/16][15 - b%16] = spi.miso;
      oe_ok &= spi.miso_oe;
      spi.sck = 1'b1;
      tick(8);
      spi.sck = 1'b0;
    end
    tick(8);
    spi.ss_n = 1'b1;
    for (int t = 1; t <= gap; t++) begin
      tick(1);
      if ((frame_valid || frame_error) && lat < 0) begin
        lat = t;
        fc_at_pulse = frame_count;
      end
      n_valid += int'(frame_valid);
      n_error += int'(frame_error);
    end
  endtask

  task automatic test_reset();
    spi.ss_n = 1'b1; spi.sck = 1'b0; spi.mosi = 1'b0;
    reset_reset_n = 1'b0;
    tick(3);
    reset_reset_n = 1'b1;
    tick(2);
    checks++; if (spi.miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", spi.miso); end
    checks++; if (spi.miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe got %b want 0", spi.miso_oe); end
    checks++; if (control_mode !== 8'h00) begin errors++; $display("FAIL reset_mode got %h want 00", control_mode); end
    checks++; if (pwm_ref !== 16'h0000) begin errors++; $display("FAIL reset_pwm got %h want 0000", pwm_ref); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", frame_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", frame_error); end
    checks++; if (frame_count !== 16'h0000) begin errors++; $display("FAIL reset_count got %h want 0000", frame_count); end
  endtask

  task automatic test_directed_frame();
    position = 32'h12345678; status = 8'h05;
    velocity = $urandom; displacement = 16'($urandom); current = 16'($urandom);
    mw = '{16'h0003, 16'hFF38, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    seal_checksum();
    expect_words();
    xfer(128, 10);
    m_mode = 8'h03; m_pwm = 16'hFF38; m_count = m_count + 16'd1;
    checks++; if (n_valid != 1 || n_error != 0) begin errors++; $display("FAIL directed_pulses got valid=%0d error=%0d want 1/0", n_valid, n_error); end
    checks++; if (lat != SYNC + 2) begin errors++; $display("FAIL directed_latency got %0d want %0d", lat, SYNC + 2); end
    checks++; if (oe_ok !== 1'b1) begin errors++; $display("FAIL directed_miso_oe got %b want 1", oe_ok); end
    checks++; if (control_mode !== m_mode) begin errors++; $display("FAIL directed_mode got %h want %h", control_mode, m_mode); end
    checks++; if ($signed(pwm_ref) != -200) begin errors++; $display("FAIL directed_pwm got %0d want -200", $signed(pwm_ref)); end
    checks++; if (frame_count !== m_count) begin errors++; $display("FAIL directed_count got %h want %h", frame_count, m_count); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (sw[i] !== ew[i]) begin errors++; $display("FAIL directed_word%0d got %h want %h", i, sw[i], ew[i]); end
    end
  endtask

  task automatic test_bad_length(input int nbits);
    randomize_inputs();
    xfer(nbits, 10);
    checks++; if (n_error != 1 || n_valid != 0) begin errors++; $display("FAIL len%0d_pulses got valid=%0d error=%0d want 0/1", nbits, n_valid, n_error); end
    checks++; if (control_mode !== m_mode || pwm_ref !== m_pwm) begin errors++; $display("FAIL len%0d_outputs got %h/%h want %h/%h", nbits, control_mode, pwm_ref, m_mode, m_pwm); end
    checks++; if (frame_count !== m_count) begin errors++; $display("FAIL len%0d_count got %h want %h", nbits, frame_count, m_count); end
  endtask

  task automatic test_snapshot();
    randomize_inputs();
    position = 32'h12345678;
    expect_words();
    pos_mid = 32'hAAAAAAAA;
    mid_bit = 20;
    xfer(128, 10);
    mid_bit = -1;
    m_mode = mw[0][7:0]; m_pwm = mw[1]; m_count = m_count + 16'd1;
    checks++; if (sw[1] !== 16'h1234) begin errors++; $display("FAIL snapshot_w1 got %h want 1234", sw[1]); end
    checks++; if (sw[2] !== 16'h5678) begin errors++; $display("FAIL snapshot_w2 got %h want 5678", sw[2]); end
    checks++; if (sw[7] !== ew[7]) begin errors++; $display("FAIL snapshot_w7 got %h want %h", sw[7], ew[7]); end
    checks++; if (n_valid != 1) begin errors++; $display("FAIL snapshot_valid got %0d want 1", n_valid); end
  endtask

  task automatic test_random_frames();
    for (int r = 0; r < 4; r++) begin
      randomize_inputs();
      expect_words();
      xfer(128, 10);
      m_mode = mw[0][7:0]; m_pwm = mw[1]; m_count = m_count + 16'd1;
      checks++; if (n_valid != 1 || n_error != 0) begin errors++; $display("FAIL rand%0d_pulses got valid=%0d error=%0d want 1/0", r, n_valid, n_error); end
      checks++; if (control_mode !== m_mode || pwm_ref !== m_pwm) begin errors++; $display("FAIL rand%0d_outputs got %h/%h want %h/%h", r, control_mode, pwm_ref, m_mode, m_pwm); end
      checks++; if (frame_count !== m_count) begin errors++; $display("FAIL rand%0d_count got %h want %h", r, frame_count, m_count); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (sw[i] !== ew[i]) begin errors++; $display("FAIL rand%0d_word%0d got %h want %h", r, i, sw[i], ew[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    force dut.frame_count = 16'hFFFF;
    tick(2);
    release dut.frame_count;
    tick(2);
    m_count = 16'hFFFF;
    checks++; if (frame_count !== m_count) begin errors++; $display("FAIL b2b_preset got %h want ffff", frame_count); end
    randomize_inputs();
    xfer(128, 4);
    m_count = m_count + 16'd1;
    checks++; if (n_valid != 1 || fc_at_pulse !== m_count) begin errors++; $display("FAIL b2b_first got valid=%0d count=%h want 1/%h", n_valid, fc_at_pulse, m_count); end
    randomize_inputs();
    xfer(128, 10);
    m_count = m_count + 16'd1;
    m_mode = mw[0][7:0]; m_pwm = mw[1];
    checks++; if (n_valid != 1 || fc_at_pulse !== m_count) begin errors++; $display("FAIL b2b_second got valid=%0d count=%h want 1/%h", n_valid, fc_at_pulse, m_count); end
    checks++; if (control_mode !== m_mode || pwm_ref !== m_pwm) begin errors++; $display("FAIL b2b_outputs got %h/%h want %h/%h", control_mode, pwm_ref, m_mode, m_pwm); end
  endtask

  task automatic test_last_word();
    randomize_inputs();
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
    mw[7] ^= 16'(1 << $urandom_range(15, 0));
    xfer(128, 10);
    checks++; if (n_error != 1 || n_valid != 0) begin errors++; $display("FAIL csum_bad got valid=%0d error=%0d want 0/1", n_valid, n_error); end
    checks++; if (control_mode !== m_mode || pwm_ref !== m_pwm || frame_count !== m_count) begin errors++; $display("FAIL csum_bad_outputs got %h/%h/%h want %h/%h/%h", control_mode, pwm_ref, frame_count, m_mode, m_pwm, m_count); end
`else
    mw[7] = 16'($urandom) | 16'h0001;
    xfer(128, 10);
    m_mode = mw[0][7:0]; m_pwm = mw[1]; m_count = m_count + 16'd1;
    checks++; if (n_valid != 1 || n_error != 0) begin errors++; $display("FAIL lastword_ignored got valid=%0d error=%0d want 1/0", n_valid, n_error); end
    checks++; if (sw[7] !== 16'h0000) begin errors++; $display("FAIL lastword_tx got %h want 0000", sw[7]); end
    checks++; if (control_mode !== m_mode || pwm_ref !== m_pwm || frame_count !== m_count) begin errors++; $display("FAIL lastword_outputs got %h/%h/%h want %h/%h/%h", control_mode, pwm_ref, frame_count, m_mode, m_pwm, m_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_directed_frame();
    test_bad_length(37);
    test_bad_length(130);
    test_snapshot();
    test_random_frames();
    test_back_to_back();
    test_last_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
